// File: rtl/data_memory_arbiter_if.sv
// Bus bundle between the two Avalon-MM masters (A = CPU data port,
// B = crypto DMA port), the arbiter and the data memory s1 port.
//   a_*/b_*   : per-master command, waitrequest and read return
//   mem_*     : muxed command to the memory and its read data
// Modports:
//   slave  : arbiter view (accepts master commands, drives the memory)
//   master : environment view (masters and memory model)
// Handshake: a command (read or write strobe) is held by the master until
// a cycle where the strobe is high and waitrequest is low; that cycle is
// the transfer. Read data returns exactly one cycle later with the
// matching readdatavalid high for one cycle.
interface data_memory_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] a_address;
  logic [BE_W-1:0]   a_byteenable;
  logic              a_read;
  logic              a_write;
  logic [DATA_W-1:0] a_writedata;
  logic              a_waitrequest;
  logic [DATA_W-1:0] a_readdata;
  logic              a_readdatavalid;

  logic [ADDR_W-1:0] b_address;
  logic [BE_W-1:0]   b_byteenable;
  logic              b_read;
  logic              b_write;
  logic [DATA_W-1:0] b_writedata;
  logic              b_waitrequest;
  logic [DATA_W-1:0] b_readdata;
  logic              b_readdatavalid;

  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  modport slave (
    input  a_address, a_byteenable, a_read, a_write, a_writedata,
    output a_waitrequest, a_readdata, a_readdatavalid,
    input  b_address, b_byteenable, b_read, b_write, b_writedata,
    output b_waitrequest, b_readdata, b_readdatavalid,
    output mem_address, mem_byteenable, mem_chipselect, mem_write,
    output mem_writedata, mem_clken,
    input  mem_readdata
  );

  modport master (
    output a_address, a_byteenable, a_read, a_write, a_writedata,
    input  a_waitrequest, a_readdata, a_readdatavalid,
    output b_address, b_byteenable, b_read, b_write, b_writedata,
    input  b_waitrequest, b_readdata, b_readdatavalid,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write,
    input  mem_writedata, mem_clken,
    output mem_readdata
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// Shares the single-port data memory between master A and master B.
// Arbitration is combinational in the request cycle: a lone requester is
// granted immediately; on a tie the previous owner keeps the memory while
// its run of consecutive grants is between 1 and MAX_HOLD-1, otherwise the
// other master wins. Reads return one cycle after issue.
// Ports:
//   clk, reset_n    : clock, asynchronous active-low reset
//   bus (slave)     : master A/B commands and the memory s1 port
//   stall_count     : saturating count of cycles with any master stalled
//   proto_err       : sticky, a master drove read and write together
//   o_dbg_last      : owner of the most recent grant (0 = A, 1 = B)
//   o_dbg_run_cnt   : consecutive grants to that owner (saturating)
module data_memory_arbiter #(
  parameter  int ADDR_W   = 12,
  parameter  int DATA_W   = 32,
  parameter  int MAX_HOLD = 4,
  parameter  int CNT_W    = 16,
  localparam int RUN_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  data_memory_arbiter_if.slave bus,
  output logic [CNT_W-1:0]     stall_count,
  output logic                 proto_err,
  output logic                 o_dbg_last,
  output logic [RUN_W-1:0]     o_dbg_run_cnt
);
  localparam int BE_W = DATA_W / 8;

  typedef enum logic {OWNER_A = 1'b0, OWNER_B = 1'b1} owner_t;

  owner_t           r_last;
  logic [RUN_W-1:0] r_run_cnt;
  logic             r_rd_pend;
  owner_t           r_rd_id;
  logic [CNT_W-1:0] r_stall_count;
  logic             r_proto_err;

  logic w_req_a, w_req_b, w_keep, w_gnt_a, w_gnt_b, w_gnt_any;
  logic w_gnt_write;
  owner_t w_gnt_owner;

  assign w_req_a = bus.a_read | bus.a_write;
  assign w_req_b = bus.b_read | bus.b_write;

  // On a tie the previous owner keeps the memory only mid-run; a run count
  // of zero (idle last cycle, or just out of reset) hands the tie over.
  assign w_keep  = (r_run_cnt != {RUN_W{1'b0}}) && (r_run_cnt < RUN_W'(MAX_HOLD));
  assign w_gnt_b = w_req_b & (~w_req_a | (w_keep ? (r_last == OWNER_B)
                                                 : (r_last == OWNER_A)));
  assign w_gnt_a = w_req_a & ~w_gnt_b;
  assign w_gnt_any   = w_gnt_a | w_gnt_b;
  assign w_gnt_owner = w_gnt_b ? OWNER_B : OWNER_A;

  // Write wins over read when a master drives both strobes.
  assign w_gnt_write = w_gnt_b ? bus.b_write : (w_gnt_a & bus.a_write);

  assign bus.a_waitrequest = w_req_a & ~w_gnt_a;
  assign bus.b_waitrequest = w_req_b & ~w_gnt_b;

  assign bus.mem_address    = w_gnt_b ? bus.b_address   : bus.a_address;
  assign bus.mem_writedata  = w_gnt_b ? bus.b_writedata : bus.a_writedata;
  assign bus.mem_byteenable = ~w_gnt_write ? {BE_W{1'b1}}
                            : (w_gnt_b ? bus.b_byteenable : bus.a_byteenable);
  assign bus.mem_chipselect = w_gnt_any;
  assign bus.mem_write      = w_gnt_write;
  assign bus.mem_clken      = 1'b1;

  assign bus.a_readdata      = bus.mem_readdata;
  assign bus.b_readdata      = bus.mem_readdata;
  assign bus.a_readdatavalid = r_rd_pend & (r_rd_id == OWNER_A);
  assign bus.b_readdatavalid = r_rd_pend & (r_rd_id == OWNER_B);

  assign stall_count   = r_stall_count;
  assign proto_err     = r_proto_err;
  assign o_dbg_last    = r_last;
  assign o_dbg_run_cnt = r_run_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last        <= OWNER_B;
      r_run_cnt     <= {RUN_W{1'b0}};
      r_rd_pend     <= 1'b0;
      r_rd_id       <= OWNER_A;
      r_stall_count <= {CNT_W{1'b0}};
      r_proto_err   <= 1'b0;
    end else begin
      if (!w_gnt_any) begin
        r_run_cnt <= {RUN_W{1'b0}};
      end else if (w_gnt_owner == r_last) begin
        if (r_run_cnt != RUN_W'(MAX_HOLD)) r_run_cnt <= r_run_cnt + 1'b1;
      end else begin
        r_last    <= w_gnt_owner;
        r_run_cnt <= RUN_W'(1);
      end

      r_rd_pend <= w_gnt_any & ~w_gnt_write;
      if (w_gnt_any) r_rd_id <= w_gnt_owner;

      if ((bus.a_waitrequest | bus.b_waitrequest) &&
          (r_stall_count != {CNT_W{1'b1}}))
        r_stall_count <= r_stall_count + 1'b1;

      if ((bus.a_read & bus.a_write) | (bus.b_read & bus.b_write))
        r_proto_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_data_memory_arbiter.sv
module tb_data_memory_arbiter;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int MAX_HOLD = 4;
  localparam int CNT_W = 16;
  localparam int RUN_W = $clog2(MAX_HOLD + 1);

  logic clk;
  logic reset_n;
  logic [CNT_W-1:0] stall_count;
  logic proto_err;
  logic dbg_last;
  logic [RUN_W-1:0] dbg_run_cnt;

  data_memory_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  data_memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD),
                        .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .stall_count(stall_count), .proto_err(proto_err),
    .o_dbg_last(dbg_last), .o_dbg_run_cnt(dbg_run_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- memory model (environment) ----------------
  logic [31:0] mem [0:4095];
  logic [31:0] mem_rd;
  assign bus.mem_readdata = mem_rd;

  always @(posedge clk) begin
    if (bus.mem_chipselect) begin
      if (bus.mem_write) begin
        for (int i = 0; i < 4; i++)
          if (bus.mem_byteenable[i]) mem[bus.mem_address][i*8 +: 8] <= bus.mem_writedata[i*8 +: 8];
      end else begin
        mem_rd <= mem[bus.mem_address];
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [31:0] ref_mem [0:63];
  logic [32:0] exp_q[$];   // {requester id, expected read data}
  int a_acc_cyc, b_acc_cyc, a_val_cyc, b_val_cyc;
  int a_vcnt = 0;
  int b_vcnt = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  always @(negedge clk) begin
    logic [32:0] e;
    logic a_acc, b_acc;
    // read return side first: the oldest expectation is at the queue head
    if (bus.a_readdatavalid && bus.b_readdatavalid) check("dual_valid", 1, 0);
    if (bus.a_readdatavalid || bus.b_readdatavalid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {bus.a_readdatavalid, bus.b_readdatavalid}, 0);
      end else begin
        e = exp_q.pop_front();
        check("rd_id", {63'd0, bus.b_readdatavalid}, {63'd0, e[32]});
        check("rd_data", bus.b_readdatavalid ? bus.b_readdata : bus.a_readdata, e[31:0]);
      end
      if (bus.a_readdatavalid) begin a_val_cyc = cyc; a_vcnt++; end
      if (bus.b_readdatavalid) begin b_val_cyc = cyc; b_vcnt++; end
    end
    a_acc = (bus.a_read | bus.a_write) & ~bus.a_waitrequest;
    b_acc = (bus.b_read | bus.b_write) & ~bus.b_waitrequest;
    if (a_acc && b_acc) check("dual_grant", 1, 0);
    if (a_acc) begin
      a_acc_cyc = cyc;
      if (bus.a_write)
        ref_mem[bus.a_address[5:0]] = merge(ref_mem[bus.a_address[5:0]], bus.a_writedata, bus.a_byteenable);
      else
        exp_q.push_back({1'b0, ref_mem[bus.a_address[5:0]]});
    end
    if (b_acc) begin
      b_acc_cyc = cyc;
      if (bus.b_write)
        ref_mem[bus.b_address[5:0]] = merge(ref_mem[bus.b_address[5:0]], bus.b_writedata, bus.b_byteenable);
      else
        exp_q.push_back({1'b1, ref_mem[bus.b_address[5:0]]});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_reset();
    reset_n = 1'b0;
    exp_q.delete();  // pending reads are dropped by reset
    repeat (2) @(negedge clk);
    check("rst_a_valid", bus.a_readdatavalid, 0);
    check("rst_b_valid", bus.b_readdatavalid, 0);
    check("rst_stall", stall_count, 0);
    check("rst_proto", proto_err, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  // Issue one command on master sel (0 = A, 1 = B) and hold it until accepted.
  task automatic xfer(input logic sel, input logic rd, input logic wr,
                      input logic [11:0] addr, input logic [3:0] be,
                      input logic [31:0] wd, output int waits);
    logic wait_now;
    if (sel) begin
      bus.b_read = rd; bus.b_write = wr; bus.b_address = addr;
      bus.b_byteenable = be; bus.b_writedata = wd;
    end else begin
      bus.a_read = rd; bus.a_write = wr; bus.a_address = addr;
      bus.a_byteenable = be; bus.a_writedata = wd;
    end
    waits = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      wait_now = sel ? bus.b_waitrequest : bus.a_waitrequest;
      if (!wait_now) break;
      waits++;
    end
    if (waits >= 50) check("accept_timeout", {63'd0, sel}, 64'hFFFF);
    @(posedge clk); #1;
    if (sel) begin bus.b_read = 0; bus.b_write = 0; end
    else begin bus.a_read = 0; bus.a_write = 0; end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w, wb, av0, bv0;
    logic a_acc, b_acc;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h1000_0000 + i;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h1000_0000 + i;
    mem[1] = 32'h11; ref_mem[1] = 32'h11;
    mem[2] = 32'h22; ref_mem[2] = 32'h22;
    bus.a_read = 0; bus.a_write = 0; bus.a_address = 0; bus.a_byteenable = 0; bus.a_writedata = 0;
    bus.b_read = 0; bus.b_write = 0; bus.b_address = 0; bus.b_byteenable = 0; bus.b_writedata = 0;
    drive_reset();

    // 1: A write then read back
    xfer(0, 0, 1, 12'h010, 4'hF, 32'hDEADBEEF, w);
    check("t1_wr_wait", w, 0);
    xfer(0, 1, 0, 12'h010, 4'h0, 32'h0, w);
    check("t1_rd_wait", w, 0);
    idle(2);
    check("t1_latency", a_val_cyc - a_acc_cyc, 1);

    // 2: B partial write, read back; A sees no valid
    av0 = a_vcnt; bv0 = b_vcnt;
    xfer(1, 0, 1, 12'h020, 4'b0011, 32'hA5A5A5A5, w);
    xfer(1, 1, 0, 12'h020, 4'h0, 32'h0, w);
    idle(2);
    check("t2_ref", ref_mem[32], 32'h1000A5A5);
    check("t2_a_valids", a_vcnt - av0, 0);
    check("t2_b_valids", b_vcnt - bv0, 1);

    // 3: both masters hold reads continuously from reset
    drive_reset();
    bus.a_read = 1; bus.a_address = 12'h001;
    bus.b_read = 1; bus.b_address = 12'h002;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      a_acc = bus.a_read & ~bus.a_waitrequest;
      b_acc = bus.b_read & ~bus.b_waitrequest;
      check($sformatf("t3_grant%0d", i), {a_acc, b_acc}, ((i / 4) % 2 == 1) ? 2'b01 : 2'b10);
      @(posedge clk); #1;
    end
    bus.a_read = 0; bus.b_read = 0;
    @(negedge clk);
    check("t3_stall", stall_count, 12);
    idle(2);

    // 4: simultaneous single reads after reset
    drive_reset();
    fork
      xfer(0, 1, 0, 12'h001, 4'h0, 32'h0, w);
      xfer(1, 1, 0, 12'h002, 4'h0, 32'h0, wb);
    join
    idle(3);
    check("t4_b_after_a", b_acc_cyc - a_acc_cyc, 1);
    check("t4_a_valid", a_val_cyc - a_acc_cyc, 1);
    check("t4_b_valid", b_val_cyc - a_acc_cyc, 2);
    check("t4_b_wait", wb, 1);

    // 5: reset right after an accepted read
    av0 = a_vcnt;
    xfer(0, 1, 0, 12'h005, 4'h0, 32'h0, w);
    drive_reset();
    idle(3);
    check("t5_no_valid", a_vcnt - av0, 0);
    check("t5_run_cnt", dbg_run_cnt, 0);

    // 6: read+write together on A
    xfer(0, 1, 1, 12'h030, 4'hF, 32'hCAFEF00D, w);
    @(negedge clk);
    check("t6_proto", proto_err, 1);
    xfer(0, 1, 0, 12'h030, 4'h0, 32'h0, w);
    idle(5);
    check("t6_proto_sticky", proto_err, 1);
    check("t6_ref", ref_mem[48], 32'hCAFEF00D);
    drive_reset();

    // random traffic on both masters
    fork
      for (int i = 0; i < 20; i++) begin
        int ww;
        logic wr;
        wr = 1'($urandom_range(0, 1));
        xfer(0, ~wr, wr, 12'($urandom_range(0, 15)), 4'($urandom_range(1, 15)), $urandom, ww);
        idle($urandom_range(0, 2));
      end
      for (int i = 0; i < 20; i++) begin
        int ww;
        logic wr;
        wr = 1'($urandom_range(0, 1));
        xfer(1, ~wr, wr, 12'($urandom_range(0, 15)), 4'($urandom_range(1, 15)), $urandom, ww);
        idle($urandom_range(0, 2));
      end
    join
    idle(4);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_proto", proto_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
